// File: rtl/pio_panel_pkg.sv
// Shared constants, converter state encoding and the seven-segment helper
// for the panel PIO responder.
package pio_panel_pkg;

    localparam int VALUE_W = 20;
    localparam int DIGITS  = 6;
    localparam int BCD_W   = 4 * DIGITS;

    localparam logic [VALUE_W-1:0] MODULUS = 20'd1000000;

    // Active-high g..a codes for digits 0..9 (index 0 is the rightmost entry).
    localparam logic [9:0][7:0] SEG7 = {
        8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D,
        8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    localparam logic [3:0][VALUE_W-1:0] STEP = {
        20'd1000, 20'd100, 20'd10, 20'd1
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } conv_state_e;

    function automatic logic [7:0] seg7_encode(input logic [3:0] bcd, input logic active_low);
        logic [7:0] raw;
        if (bcd <= 4'd9) begin
            raw = SEG7[bcd];
        end else begin
            raw = 8'h00;
        end
        return active_low ? ~raw : raw;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter; one bit per SHIFT cycle,
// result registered on entry to DONE and held until the next conversion.
module bin2bcd_seq
    import pio_panel_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [VALUE_W-1:0] bin_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [BCD_W-1:0]   bcd_o
);

    localparam int WORK_W = BCD_W + VALUE_W;

    conv_state_e       state_q;
    logic [4:0]        cnt_q;
    logic [WORK_W-1:0] work_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [WORK_W-1:0] adj_s;
    logic [WORK_W-1:0] shifted_s;

    // Add 3 to every BCD nibble that is 5 or more, then shift one bit left.
    always_comb begin
        adj_s = work_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (work_q[VALUE_W + 4*d +: 4] >= 4'd5) begin
                adj_s[VALUE_W + 4*d +: 4] = work_q[VALUE_W + 4*d +: 4] + 4'd3;
            end else begin
                adj_s[VALUE_W + 4*d +: 4] = work_q[VALUE_W + 4*d +: 4];
            end
        end
        shifted_s = {adj_s[WORK_W-2:0], 1'b0};
    end

    // Converter FSM; DONE re-enters LOAD directly when a new start is waiting.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            work_q  <= '0;
            bcd_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= start_i ? LOAD : IDLE;
                end
                LOAD: begin
                    work_q  <= {{BCD_W{1'b0}}, bin_i};
                    cnt_q   <= 5'd0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    work_q <= shifted_s;
                    if (cnt_q == 5'd19) begin
                        bcd_q   <= shifted_s[WORK_W-1 -: BCD_W];
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                DONE: begin
                    state_q <= start_i ? LOAD : IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/pio_panel_responder.sv
// Panel responder: synchronises and debounces the HPS-driven buttons, keeps a
// 0..999999 counter and drives seven-segment codes and status back to the PIOs.
module pio_panel_responder
    import pio_panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2,
    parameter bit SEG_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  button_in,
    input  logic [2:0]  dipsw_in,
    output logic [31:0] hex0_3_out,
    output logic [15:0] hex4_5_out,
    output logic [7:0]  led_out
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [7:0] ZERO_CODE = seg7_encode(4'd0, SEG_ACTIVE_LOW);
    localparam logic [VALUE_W:0] MOD_EXT = {1'b0, MODULUS};

    logic [SYNC_STAGES-1:0][5:0] sync_q;
    logic [2:0]                  btn_s;
    logic [2:0]                  dip_s;
    logic [2:0][CNT_W-1:0]       db_cnt_q;
    logic [2:0]                  db_q;
    logic [2:0]                  press_q;
    logic [VALUE_W-1:0]          value_q;
    logic [VALUE_W-1:0]          value_d;
    logic [VALUE_W-1:0]          step_s;
    logic [VALUE_W:0]            sum_s;
    logic                        change_s;
    logic                        pending_q;
    logic                        busy_s;
    logic                        done_s;
    logic [BCD_W-1:0]            bcd_s;
    logic [8*DIGITS-1:0]         hex_enc_s;
    logic [31:0]                 hex0_3_q;
    logic [15:0]                 hex4_5_q;
    logic [7:0]                  led_q;

    assign btn_s = sync_q[SYNC_STAGES-1][2:0];
    assign dip_s = sync_q[SYNC_STAGES-1][5:3];

    // Input synchroniser and per-button debounce; press_q pulses on an accepted 0->1.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            db_cnt_q <= '0;
            db_q     <= 3'b000;
            press_q  <= 3'b000;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {dipsw_in, button_in}};
            for (int b = 0; b < 3; b++) begin
                if (btn_s[b] == db_q[b]) begin
                    db_cnt_q[b] <= '0;
                    press_q[b]  <= 1'b0;
                end else if (db_cnt_q[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt_q[b] <= '0;
                    db_q[b]     <= btn_s[b];
                    press_q[b]  <= btn_s[b];
                end else begin
                    db_cnt_q[b] <= db_cnt_q[b] + 1'b1;
                    press_q[b]  <= 1'b0;
                end
            end
        end
    end

    // Counter update: clear wins, freeze blocks inc/dec, simultaneous inc+dec cancel.
    always_comb begin
        step_s   = STEP[dip_s[1:0]];
        sum_s    = {1'b0, value_q} + {1'b0, step_s};
        value_d  = value_q;
        change_s = 1'b0;
        if (press_q[2]) begin
            value_d  = '0;
            change_s = 1'b1;
        end else if (!dip_s[2] && (press_q[0] != press_q[1])) begin
            change_s = 1'b1;
            if (press_q[0]) begin
                value_d = (sum_s >= MOD_EXT) ? VALUE_W'(sum_s - MOD_EXT) : sum_s[VALUE_W-1:0];
            end else if (value_q >= step_s) begin
                value_d = value_q - step_s;
            end else begin
                value_d = value_q + (MODULUS - step_s);
            end
        end else begin
            value_d  = value_q;
            change_s = 1'b0;
        end
    end

    bin2bcd_seq u_conv (
        .clk_i   (clk),
        .reset_i (reset),
        .start_i (change_s | pending_q),
        .bin_i   (value_q),
        .busy_o  (busy_s),
        .done_o  (done_s),
        .bcd_o   (bcd_s)
    );

    // Segment codes for the converter's held BCD result.
    always_comb begin
        hex_enc_s = '0;
        for (int d = 0; d < DIGITS; d++) begin
            hex_enc_s[8*d +: 8] = seg7_encode(bcd_s[4*d +: 4], SEG_ACTIVE_LOW);
        end
    end

    // Value, pending flag, display and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q   <= '0;
            pending_q <= 1'b0;
            hex0_3_q  <= {4{ZERO_CODE}};
            hex4_5_q  <= {2{ZERO_CODE}};
            led_q     <= 8'h00;
        end else begin
            value_q <= value_d;
            // A change landing in DONE restarts the converter directly, so no pending needed.
            if (change_s && busy_s && !done_s) begin
                pending_q <= 1'b1;
            end else if (done_s) begin
                pending_q <= 1'b0;
            end else begin
                pending_q <= pending_q;
            end
            if (done_s) begin
                hex0_3_q <= hex_enc_s[31:0];
                hex4_5_q <= hex_enc_s[47:32];
            end else begin
                hex0_3_q <= hex0_3_q;
                hex4_5_q <= hex4_5_q;
            end
            led_q <= {dip_s, db_q, pending_q, busy_s};
        end
    end

    assign hex0_3_out = hex0_3_q;
    assign hex4_5_out = hex4_5_q;
    assign led_out    = led_q;

endmodule

// File: tb/tb_pio_panel_responder.sv
// Directed bench for pio_panel_responder with a scoreboard of expected displays.
module tb_pio_panel_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  button_in;
    logic [2:0]  dipsw_in;
    logic [31:0] hex0_3_out;
    logic [15:0] hex4_5_out;
    logic [7:0]  led_out;

    int checks = 0;
    int passes = 0;
    int model_value = 0;
    logic [47:0] sb_q [$];

    localparam logic [7:0] SEG_LUT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    pio_panel_responder #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2),
        .SEG_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .button_in  (button_in),
        .dipsw_in   (dipsw_in),
        .hex0_3_out (hex0_3_out),
        .hex4_5_out (hex4_5_out),
        .led_out    (led_out)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] model_hex(input int v);
        logic [47:0] r;
        int t;
        t = v;
        r = '0;
        for (int k = 0; k < 6; k++) begin
            r[8*k +: 8] = SEG_LUT[t % 10];
            t = t / 10;
        end
        return r;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic push_expect();
        sb_q.push_back(model_hex(model_value));
    endtask

    task automatic pulse(input logic [2:0] mask);
        button_in = mask;
        tick(10);
        button_in = 3'b000;
        tick(10);
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 60 && led_out[0] !== 1'b1; i++) tick();
        check("busy_seen", {31'd0, led_out[0]}, 32'd1);
    endtask

    task automatic settle_compare(input string tag);
        logic [47:0] exp;
        for (int i = 0; i < 100 && led_out[1:0] !== 2'b00; i++) tick();
        tick(2);
        check({tag, "_idle"}, {30'd0, led_out[1:0]}, 32'd0);
        exp = sb_q.pop_front();
        check({tag, "_hex0_3"}, hex0_3_out, exp[31:0]);
        check({tag, "_hex4_5"}, {16'd0, hex4_5_out}, {16'd0, exp[47:32]});
    endtask

    task automatic set_dip(input logic [2:0] d);
        dipsw_in = d;
        tick(4);
    endtask

    initial begin
        int n;
        int falls;
        logic saw_pend;
        logic prev_busy;
        logic [31:0] old_hex;

        reset = 1'b1;
        button_in = 3'b000;
        dipsw_in = 3'b000;
        tick(3);
        reset = 1'b0;
        tick(50);
        check("rst_hex0_3", hex0_3_out, 32'hC0C0C0C0);
        check("rst_hex4_5", {16'd0, hex4_5_out}, 32'h0000C0C0);
        check("rst_led", {24'd0, led_out}, 32'd0);

        // Exact display latency for a single inc of 1000.
        set_dip(3'b011);
        old_hex = hex0_3_out;
        button_in = 3'b001;
        wait_busy();
        n = 0;
        while (hex0_3_out === old_hex && n < 40) begin
            tick();
            n++;
        end
        check("latency", n, 32'd21);
        button_in = 3'b000;
        tick(10);
        model_value = 1000;
        push_expect();
        settle_compare("inc1000");

        // Wrap-around both ways.
        pulse(3'b010);
        model_value = 0;
        push_expect();
        settle_compare("dec_to0");
        set_dip(3'b000);
        pulse(3'b010);
        model_value = 999999;
        push_expect();
        settle_compare("dec_wrap");
        set_dip(3'b011);
        pulse(3'b001);
        model_value = 999;
        push_expect();
        settle_compare("inc_wrap");

        // Bouncing inc, then a clean hold: exactly one increment.
        set_dip(3'b000);
        for (int i = 0; i < 5; i++) begin
            button_in = 3'b001;
            tick(2);
            button_in = 3'b000;
            tick(2);
        end
        button_in = 3'b001;
        tick(12);
        button_in = 3'b000;
        tick(10);
        model_value = 1000;
        push_expect();
        settle_compare("bounce");

        // Second inc lands during SHIFT: pending set, busy never drops in between.
        button_in = 3'b001;
        wait_busy();
        button_in = 3'b000;
        saw_pend = 1'b0;
        falls = 0;
        prev_busy = 1'b1;
        for (int i = 0; i < 110; i++) begin
            if (i == 8) button_in = 3'b001;
            if (i == 18) button_in = 3'b000;
            tick();
            saw_pend = saw_pend | led_out[1];
            if (prev_busy && !led_out[0]) falls++;
            prev_busy = led_out[0];
        end
        check("pending_seen", {31'd0, saw_pend}, 32'd1);
        check("single_reconv", falls, 32'd1);
        model_value = 1002;
        push_expect();
        settle_compare("pending");

        pulse(3'b011);
        push_expect();
        settle_compare("inc_dec_same");

        // Build 1234.
        set_dip(3'b010);
        for (int i = 0; i < 2; i++) pulse(3'b001);
        set_dip(3'b001);
        for (int i = 0; i < 3; i++) pulse(3'b001);
        set_dip(3'b000);
        for (int i = 0; i < 2; i++) pulse(3'b001);
        model_value = 1234;
        push_expect();
        settle_compare("build1234");

        set_dip(3'b100);
        pulse(3'b001);
        push_expect();
        settle_compare("freeze_inc");
        pulse(3'b010);
        push_expect();
        settle_compare("freeze_dec");
        pulse(3'b100);
        model_value = 0;
        push_expect();
        settle_compare("freeze_clear");

        // Reset in the middle of a conversion.
        set_dip(3'b000);
        button_in = 3'b001;
        wait_busy();
        tick(5);
        button_in = 3'b000;
        reset = 1'b1;
        tick();
        check("midrst_hex0_3", hex0_3_out, 32'hC0C0C0C0);
        check("midrst_hex4_5", {16'd0, hex4_5_out}, 32'h0000C0C0);
        check("midrst_led", {24'd0, led_out}, 32'd0);
        reset = 1'b0;
        tick(5);
        check("postrst_led", {24'd0, led_out}, 32'd0);
        pulse(3'b001);
        model_value = 1;
        push_expect();
        settle_compare("postrst_inc");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
